// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory stage of a five-stage pipeline. It latches execute results into the
// M register, runs a two-state request/acknowledge handshake with data memory
// (with a bounded wait), resolves branches, and produces the W register for
// writeback.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   *_E                 execute-stage results and control bits
//   mem_req/we/addr/wdata  data memory request (held for the whole BUSY wait)
//   mem_ack, mem_rdata  memory completion and load data
//   PCSrc_M, PCBranch_M taken-branch redirect to fetch
//   stall_M             hold upstream stages while memory is outstanding
//   mem_err             sticky flag: a memory access timed out
//   *_W                 writeback-stage register outputs
// -----------------------------------------------------------------------------
module mem_stage #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_E,
   input  logic [63:0] PCBranch_E,
   input  logic [63:0] aluResult_E,
   input  logic [63:0] writeData_E,
   input  logic        zero_E,
   input  logic        regWrite_E,
   input  logic        memRead_E,
   input  logic        memWrite_E,
   input  logic        memtoReg_E,
   input  logic        branch_E,
   input  logic [4:0]  rd_E,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [63:0] mem_rdata,
   output logic        PCSrc_M,
   output logic [63:0] PCBranch_M,
   output logic        stall_M,
   output logic        mem_err,
   output logic        valid_W,
   output logic        regWrite_W,
   output logic        memtoReg_W,
   output logic [63:0] aluResult_W,
   output logic [63:0] readData_W,
   output logic [4:0]  rd_W
);

   localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mem_err_q;
   logic          busy, timeout, start_mem;

   // M register
   logic        valid_m_q, zero_m_q, reg_write_m_q, mem_read_m_q;
   logic        mem_write_m_q, memto_reg_m_q, branch_m_q;
   logic [63:0] pc_branch_m_q, alu_result_m_q, write_data_m_q;
   logic [4:0]  rd_m_q;

   // W register
   logic        valid_w_q, reg_write_w_q, memto_reg_w_q;
   logic [63:0] alu_result_w_q, read_data_w_q;
   logic [4:0]  rd_w_q;

   assign busy    = (state_q == BUSY);
   // Ack on the last allowed cycle wins over the timeout.
   assign timeout = busy & ~mem_ack & (cnt_q == CNT_LAST);
   assign stall_M = busy & ~mem_ack & ~timeout;
   assign PCSrc_M = valid_m_q & branch_m_q & zero_m_q;

   // A memory op enters BUSY on the edge that loads it into M; a squashed
   // (flushed) instruction never reaches M and so never starts an access.
   assign start_mem = ~stall_M & ~PCSrc_M & valid_E & (memRead_E | memWrite_E);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      state_d = IDLE;
      cnt_d   = '0;
      if (start_mem) begin
         state_d = BUSY;
         cnt_d   = '0;
      end else if (stall_M) begin
         state_d = BUSY;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_q | timeout;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_m_q      <= 1'b0;
         zero_m_q       <= 1'b0;
         reg_write_m_q  <= 1'b0;
         mem_read_m_q   <= 1'b0;
         mem_write_m_q  <= 1'b0;
         memto_reg_m_q  <= 1'b0;
         branch_m_q     <= 1'b0;
         pc_branch_m_q  <= '0;
         alu_result_m_q <= '0;
         write_data_m_q <= '0;
         rd_m_q         <= '0;
      end else if (!stall_M) begin
         pc_branch_m_q  <= PCBranch_E;
         alu_result_m_q <= aluResult_E;
         write_data_m_q <= writeData_E;
         zero_m_q       <= zero_E;
         rd_m_q         <= rd_E;
         // A taken branch in M squashes the instruction behind it.
         valid_m_q      <= valid_E & ~PCSrc_M;
         reg_write_m_q  <= regWrite_E & ~PCSrc_M;
         mem_read_m_q   <= memRead_E & ~PCSrc_M;
         mem_write_m_q  <= memWrite_E & ~PCSrc_M;
         memto_reg_m_q  <= memtoReg_E & ~PCSrc_M;
         branch_m_q     <= branch_E & ~PCSrc_M;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_w_q      <= 1'b0;
         reg_write_w_q  <= 1'b0;
         memto_reg_w_q  <= 1'b0;
         alu_result_w_q <= '0;
         read_data_w_q  <= '0;
         rd_w_q         <= '0;
      end else if (stall_M) begin
         // Insert a bubble into W; data fields keep their old contents.
         valid_w_q     <= 1'b0;
         reg_write_w_q <= 1'b0;
         memto_reg_w_q <= 1'b0;
      end else begin
         valid_w_q      <= valid_m_q;
         // A timed-out access still retires but must not write the register file.
         reg_write_w_q  <= reg_write_m_q & ~timeout;
         memto_reg_w_q  <= memto_reg_m_q;
         alu_result_w_q <= alu_result_m_q;
         rd_w_q         <= rd_m_q;
         read_data_w_q  <= (busy & mem_ack & mem_read_m_q) ? mem_rdata : '0;
      end
   end

   assign mem_req     = busy;
   assign mem_we      = busy & mem_write_m_q;
   assign mem_addr    = alu_result_m_q;
   assign mem_wdata   = write_data_m_q;
   assign PCBranch_M  = pc_branch_m_q;
   assign mem_err     = mem_err_q;
   assign valid_W     = valid_w_q;
   assign regWrite_W  = reg_write_w_q;
   assign memtoReg_W  = memto_reg_w_q;
   assign aluResult_W = alu_result_w_q;
   assign readData_W  = read_data_w_q;
   assign rd_W        = rd_w_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. Issued instructions push their expected
// writeback record to a queue; a monitor pops and compares whenever valid_W
// is seen. A small memory responder acknowledges after a configurable number
// of BUSY cycles (0 = never). Directed checks cover handshake timing, branch
// squash, timeout, and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mem_stage;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid_E = 1'b0;
   logic [63:0] PCBranch_E = '0, aluResult_E = '0, writeData_E = '0;
   logic        zero_E = 1'b0, regWrite_E = 1'b0, memRead_E = 1'b0;
   logic        memWrite_E = 1'b0, memtoReg_E = 1'b0, branch_E = 1'b0;
   logic [4:0]  rd_E = '0;
   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic        PCSrc_M, stall_M, mem_err;
   logic [63:0] PCBranch_M;
   logic        valid_W, regWrite_W, memtoReg_W;
   logic [63:0] aluResult_W, readData_W;
   logic [4:0]  rd_W;

   always #5 clk = ~clk;

   mem_stage #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .valid_E(valid_E),
      .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
      .zero_E(zero_E), .regWrite_E(regWrite_E), .memRead_E(memRead_E),
      .memWrite_E(memWrite_E), .memtoReg_E(memtoReg_E), .branch_E(branch_E),
      .rd_E(rd_E), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M), .stall_M(stall_M),
      .mem_err(mem_err), .valid_W(valid_W), .regWrite_W(regWrite_W),
      .memtoReg_W(memtoReg_W), .aluResult_W(aluResult_W),
      .readData_W(readData_W), .rd_W(rd_W)
   );

   typedef struct {
      logic [63:0] alu;
      logic [4:0]  rd;
      logic        rw;
      logic        m2r;
      logic        ld;
      logic [63:0] rdata;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory responder configuration
   int          ack_lat   = 1;
   logic [63:0] rdata_cfg = '0;
   logic        force_ack = 1'b0;

   // Activity counters observed on falling edges
   int          n_req = 0, n_stall = 0;
   logic        stall_vw_seen = 1'b0;
   logic [63:0] last_addr = '0, last_wdata = '0;
   logic        last_we = 1'b0;
   logic        flush_pending = 1'b0;

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset && valid_W) begin
         if (sb.size() == 0) begin
            check("w_unexpected", 64'(valid_W), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("w_alu", aluResult_W, e.alu);
            check("w_rd", 64'(rd_W), 64'(e.rd));
            check("w_regwrite", 64'(regWrite_W), 64'(e.rw));
            check("w_memtoreg", 64'(memtoReg_W), 64'(e.m2r));
            if (e.ld) check("w_rdata", readData_W, e.rdata);
         end
      end
   end

   // Request/stall activity
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_req) begin
            n_req++;
            last_addr  = mem_addr;
            last_we    = mem_we;
            last_wdata = mem_wdata;
         end
         if (stall_M) begin
            n_stall++;
            stall_vw_seen = stall_vw_seen | valid_W;
         end
      end
   end

   // Memory responder: ack on BUSY cycle number ack_lat (1-based)
   logic prev_req = 1'b0, prev_done = 1'b0;
   int   cyc = 0;

   always @(negedge clk) begin
      prev_req  = mem_req;
      prev_done = mem_req && !stall_M;
   end

   always begin
      @(posedge clk);
      #2;
      mem_rdata = rdata_cfg;
      if (mem_req) begin
         cyc = (prev_req && !prev_done) ? cyc + 1 : 0;
         mem_ack = force_ack || (ack_lat != 0 && cyc == ack_lat - 1);
      end else begin
         mem_ack = force_ack;
      end
   end

   // Present one instruction and hold it until the stage accepts it.
   task automatic issue(input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] wd,
                        input logic zero, input logic rw, input logic mr, input logic mw,
                        input logic m2r, input logic br, input logic [4:0] rd);
      exp_t e;
      logic acc, to;
      int   n;
      PCBranch_E = pc;  aluResult_E = alu; writeData_E = wd; zero_E = zero;
      regWrite_E = rw;  memRead_E = mr;    memWrite_E = mw;  memtoReg_E = m2r;
      branch_E = br;    rd_E = rd;         valid_E = 1'b1;
      if (!flush_pending) begin
         to = (mr | mw) && (ack_lat == 0 || ack_lat > TO);
         e.alu   = alu;
         e.rd    = rd;
         e.rw    = rw & ~to;
         e.m2r   = m2r;
         e.ld    = mr;
         e.rdata = (mr && !to) ? rdata_cfg : 64'd0;
         sb.push_back(e);
         flush_pending = br & zero;
      end else begin
         flush_pending = 1'b0;
      end
      n = 0;
      do begin
         @(negedge clk);
         acc = !stall_M;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 100);
      if (!acc) check("issue_accept", 64'(acc), 64'd1);
      valid_E = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      flush_pending = 1'b0;
   endtask

   // Wait until the outstanding access completes, then step past that edge.
   task automatic wait_done();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (!stall_M || n >= 100) break;
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) check("wait_done_bound", 64'(stall_M), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      n_req = 0;
      n_stall = 0;
      stall_vw_seen = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_stall", 64'(stall_M), 64'd0);
      check("rst_pcsrc", 64'(PCSrc_M), 64'd0);
      check("rst_valid_w", 64'(valid_W), 64'd0);
      check("rst_mem_err", 64'(mem_err), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ALU op: E->W in two edges, no stall
      clear_counts();
      issue(64'd0, 64'h10, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
      @(negedge clk);
      check("alu_vw_edge1", 64'(valid_W), 64'd0);
      @(negedge clk);
      check("alu_vw_edge2", 64'(valid_W), 64'd1);
      @(posedge clk);
      #1;
      issue(64'd0, 64'hABCD, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31);
      idle(2);
      check("alu_no_stall", 64'(n_stall), 64'd0);

      // Load at 0x100, ack on third BUSY cycle
      ack_lat = 3;
      rdata_cfg = 64'hDEADBEEF;
      clear_counts();
      issue(64'd0, 64'h100, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5);
      wait_done();
      check("ld_req_cycles", 64'(n_req), 64'd3);
      check("ld_stall_cycles", 64'(n_stall), 64'd2);
      check("ld_addr", last_addr, 64'h100);
      check("ld_vw_in_stall", 64'(stall_vw_seen), 64'd0);
      idle(1);

      // Store, ack in the first BUSY cycle
      ack_lat = 1;
      clear_counts();
      issue(64'd0, 64'h200, 64'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      wait_done();
      check("st_we", 64'(last_we), 64'd1);
      check("st_wdata", last_wdata, 64'h55);
      check("st_req_cycles", 64'(n_req), 64'd1);
      check("st_stall_cycles", 64'(n_stall), 64'd0);
      idle(1);

      // Back-to-back memory ops with immediate ack
      rdata_cfg = 64'h1234_5678_9ABC_DEF0;
      clear_counts();
      issue(64'd0, 64'h300, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7);
      issue(64'd0, 64'h308, 64'h77, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      issue(64'd0, 64'h310, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8);
      wait_done();
      check("b2b_req_cycles", 64'(n_req), 64'd3);
      check("b2b_stall_cycles", 64'(n_stall), 64'd0);

      // Back-to-back loads, ack on second BUSY cycle each
      ack_lat = 2;
      rdata_cfg = 64'h0BAD_F00D;
      clear_counts();
      issue(64'd0, 64'h320, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
      issue(64'd0, 64'h328, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd10);
      wait_done();
      check("b2b2_req_cycles", 64'(n_req), 64'd4);
      check("b2b2_stall_cycles", 64'(n_stall), 64'd2);
      idle(1);

      // Taken branch squashes the following instruction
      issue(64'h2000, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
      check("br_pcsrc", 64'(PCSrc_M), 64'd1);
      check("br_target", PCBranch_M, 64'h2000);
      issue(64'd0, 64'h99, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11);
      check("br_bubble_pcsrc", 64'(PCSrc_M), 64'd0);
      issue(64'd0, 64'hAA, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12);
      // Not-taken branch
      issue(64'h3000, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
      check("br_not_taken", 64'(PCSrc_M), 64'd0);
      idle(3);

      // Ack coincides with the timeout limit: no error
      ack_lat = 16;
      rdata_cfg = 64'hCAFE;
      clear_counts();
      issue(64'd0, 64'h400, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd13);
      wait_done();
      check("ack16_req_cycles", 64'(n_req), 64'd16);
      check("ack16_stall_cycles", 64'(n_stall), 64'd15);
      check("ack16_mem_err", 64'(mem_err), 64'd0);
      idle(1);

      // No ack: timeout after 16 BUSY cycles
      ack_lat = 0;
      clear_counts();
      issue(64'd0, 64'h500, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd14);
      wait_done();
      check("to_req_cycles", 64'(n_req), 64'd16);
      check("to_stall_cycles", 64'(n_stall), 64'd15);
      check("to_mem_err", 64'(mem_err), 64'd1);
      @(negedge clk);
      check("to_valid_w", 64'(valid_W), 64'd1);
      check("to_readdata_w", readData_W, 64'd0);
      idle(2);
      check("to_err_sticky", 64'(mem_err), 64'd1);

      // Reset asserted mid-BUSY with a valid instruction in W
      ack_lat = 0;
      issue(64'd0, 64'h77, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15);
      issue(64'd0, 64'h600, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd16);
      check("rstb_mem_req", 64'(mem_req), 64'd1);
      check("rstb_valid_w", 64'(valid_W), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      check("rsta_mem_req", 64'(mem_req), 64'd0);
      check("rsta_stall", 64'(stall_M), 64'd0);
      check("rsta_valid_w", 64'(valid_W), 64'd0);
      check("rsta_mem_err", 64'(mem_err), 64'd0);
      sb.delete();
      flush_pending = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      force_ack = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("post_rst_ack_req", 64'(mem_req), 64'd0);
         check("post_rst_ack_vw", 64'(valid_W), 64'd0);
      end
      force_ack = 1'b0;
      @(posedge clk);
      #1;

      // Pipeline still works after reset
      ack_lat = 1;
      issue(64'd0, 64'h42, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
      idle(3);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
